elbeth_mem_arbiter: RTL and testbench

Shares one external memory port between the core's instruction-fetch port (imem_*) and data port (dmem_*). It sits between the core and the single-port memory/bus. It grants one requester at a time with round-robin priority, registers the granted request onto the memory side and routes the response back. A response timeout keeps a hung memory from freezing the pipeline.

---
 rtl/elbeth_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_elbeth_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (imem) and data (dmem) requesters.
// Latency: request in IDLE -> registered mem_en next cycle; response routed back combinationally. Backpressure: requesters hold *_en until *_ready/*_error.
module elbeth_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_en,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_in_data,
    output logic        imem_ready,
    output logic        imem_error,
    input  logic        dmem_en,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wr,
    input  logic [31:0] dmem_w_data,
    output logic [31:0] dmem_in_data,
    output logic        dmem_ready,
    output logic        dmem_error,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_in_data,
    input  logic        mem_ready,
    input  logic        mem_error,
    output logic [1:0]  grant
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    // State encoding doubles as the grant value.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_IMEM = 2'b01;
    localparam logic [1:0] S_DMEM = 2'b10;

    logic [1:0]    state_q, state_d;
    logic          last_dmem_q, last_dmem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_wr_q, mem_wr_d;
    logic [31:0]   mem_w_data_q, mem_w_data_d;

    logic owned, timeout_hit, fin_ok, fin_err;
    logic pick_d, pick_i;

    // A completion in the very cycle the count expires is honoured rather than timed out.
    assign owned       = (state_q != S_IDLE) && !rst;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL) && !mem_ready && !mem_error;
    assign fin_err     = owned && (mem_error || timeout_hit);
    assign fin_ok      = owned && mem_ready && !mem_error;

    assign imem_ready   = fin_ok && (state_q == S_IMEM);
    assign imem_error   = fin_err && (state_q == S_IMEM);
    assign imem_in_data = imem_ready ? mem_in_data : 32'h0;
    assign dmem_ready   = fin_ok && (state_q == S_DMEM);
    assign dmem_error   = fin_err && (state_q == S_DMEM);
    assign dmem_in_data = dmem_ready ? mem_in_data : 32'h0;

    assign mem_en     = (state_q != S_IDLE);
    assign grant      = state_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr     = mem_wr_q;
    assign mem_w_data = mem_w_data_q;

    always_comb begin
        state_d      = state_q;
        last_dmem_d  = last_dmem_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wr_d     = mem_wr_q;
        mem_w_data_d = mem_w_data_q;
        pick_d       = 1'b0;
        pick_i       = 1'b0;
        if (state_q == S_IDLE) begin
            pick_d = dmem_en && (!imem_en || !last_dmem_q);
            pick_i = imem_en && !pick_d;
            if (pick_d) begin
                state_d      = S_DMEM;
                last_dmem_d  = 1'b1;
                cnt_d        = '0;
                mem_addr_d   = dmem_addr;
                mem_wr_d     = dmem_wr;
                mem_w_data_d = dmem_w_data;
            end else if (pick_i) begin
                state_d      = S_IMEM;
                last_dmem_d  = 1'b0;
                cnt_d        = '0;
                mem_addr_d   = imem_addr;
                mem_wr_d     = 4'b0000;
                mem_w_data_d = 32'h0;
            end
        end else begin
            if (mem_ready || mem_error || timeout_hit) begin
                state_d = S_IDLE;
            end else if (cnt_q != {CW{1'b1}}) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_dmem_q  <= 1'b0;
            cnt_q        <= '0;
            mem_addr_q   <= 32'h0;
            mem_wr_q     <= 4'b0000;
            mem_w_data_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_dmem_q  <= last_dmem_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_w_data_q <= mem_w_data_d;
        end
    end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter: a cycle-level reference model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_elbeth_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en, dmem_en, mem_ready, mem_error;
    logic [31:0] imem_addr, dmem_addr, dmem_w_data, mem_in_data;
    logic [3:0]  dmem_wr;
    logic [31:0] imem_in_data, dmem_in_data, mem_addr, mem_w_data;
    logic        imem_ready, imem_error, dmem_ready, dmem_error, mem_en;
    logic [3:0]  mem_wr;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    elbeth_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_in_data(imem_in_data),
        .imem_ready(imem_ready), .imem_error(imem_error),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_wr(dmem_wr), .dmem_w_data(dmem_w_data),
        .dmem_in_data(dmem_in_data), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_w_data(mem_w_data),
        .mem_in_data(mem_in_data), .mem_ready(mem_ready), .mem_error(mem_error),
        .grant(grant)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, who was served last, cycles waited, latched request.
    logic [1:0]  m_owner = 2'b00;
    logic [1:0]  m_last  = 2'b01;
    int          m_wait  = 0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [3:0]  m_wr    = 4'h0;

    always @(negedge clk) begin
        logic fe, fo, e_ir, e_ie, e_dr, e_de;
        logic [1:0] win;
        fe = !rst && (m_owner != 2'b00) &&
             (mem_error || (TO != 0 && m_wait == TO && !mem_ready));
        fo = !rst && (m_owner != 2'b00) && mem_ready && !mem_error;
        e_ir = fo && (m_owner == 2'b01);
        e_ie = fe && (m_owner == 2'b01);
        e_dr = fo && (m_owner == 2'b10);
        e_de = fe && (m_owner == 2'b10);
        if (model_on) begin
            chk("m_imem_ready", 32'(imem_ready), 32'(e_ir));
            chk("m_imem_error", 32'(imem_error), 32'(e_ie));
            chk("m_imem_in_data", imem_in_data, e_ir ? mem_in_data : 32'h0);
            chk("m_dmem_ready", 32'(dmem_ready), 32'(e_dr));
            chk("m_dmem_error", 32'(dmem_error), 32'(e_de));
            chk("m_dmem_in_data", dmem_in_data, e_dr ? mem_in_data : 32'h0);
            chk("m_mem_en", 32'(mem_en), 32'(m_owner != 2'b00));
            chk("m_grant", 32'(grant), 32'(m_owner));
            if (m_owner != 2'b00) begin
                chk("m_mem_addr", mem_addr, m_addr);
                chk("m_mem_wr", 32'(mem_wr), 32'(m_wr));
                chk("m_mem_w_data", mem_w_data, m_wdata);
            end
        end
        if (rst) begin
            m_owner = 2'b00; m_last = 2'b01; m_wait = 0;
            m_addr = 32'h0; m_wr = 4'h0; m_wdata = 32'h0;
        end else if (m_owner == 2'b00) begin
            if (imem_en && dmem_en) win = (m_last == 2'b01) ? 2'b10 : 2'b01;
            else if (dmem_en)       win = 2'b10;
            else if (imem_en)       win = 2'b01;
            else                    win = 2'b00;
            if (win == 2'b10) begin
                m_addr = dmem_addr; m_wr = dmem_wr; m_wdata = dmem_w_data;
            end else if (win == 2'b01) begin
                m_addr = imem_addr; m_wr = 4'h0; m_wdata = 32'h0;
            end
            if (win != 2'b00) begin
                m_owner = win; m_last = win; m_wait = 0;
            end
        end else if (fe || fo) begin
            m_owner = 2'b00;
        end else begin
            m_wait++;
        end
    end

    task automatic drv(input logic ie, input logic [31:0] ia, input logic de, input logic [31:0] da,
                       input logic [3:0] dw, input logic [31:0] dd,
                       input logic mr, input logic me, input logic [31:0] md);
        imem_en = ie; imem_addr = ia; dmem_en = de; dmem_addr = da; dmem_wr = dw;
        dmem_w_data = dd; mem_ready = mr; mem_error = me; mem_in_data = md;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    logic [1:0] rr_exp [6];

    initial begin
        rr_exp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        rst = 1'b1;
        idle();
        tick();
        model_on = 1'b1;
        #2;
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;

        // Single fetch with two wait cycles.
        drv(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        #2;
        chk("fetch_mem_en", 32'(mem_en), 32'h1);
        chk("fetch_mem_addr", mem_addr, 32'h40);
        chk("fetch_mem_wr", 32'(mem_wr), 32'h0);
        chk("fetch_grant", 32'(grant), 32'h1);
        tick();
        #2;
        chk("fetch_c2_ready", 32'(imem_ready), 32'h0);
        tick();
        drv(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h13);
        #2;
        chk("fetch_ready", 32'(imem_ready), 32'h1);
        chk("fetch_data", imem_in_data, 32'h13);
        chk("fetch_dmem_ready", 32'(dmem_ready), 32'h0);
        chk("fetch_dmem_data", dmem_in_data, 32'h0);
        tick();
        idle();
        #2;
        chk("fetch_done_mem_en", 32'(mem_en), 32'h0);
        tick();

        // Tie from reset, zero-wait memory, both requesters held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, 32'h200, 1'b1, 32'h300, 4'h0, 32'h0, 1'b1, 1'b0, 32'hAAAA);
            #2;
            chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
            tick();
        end
        idle();
        tick();

        // Byte-strobed write.
        drv(1'b0, 32'h0, 1'b1, 32'h100, 4'b0011, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        tick();
        drv(1'b0, 32'h0, 1'b1, 32'h100, 4'b0011, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        #2;
        chk("wr_mem_wr", 32'(mem_wr), 32'h3);
        chk("wr_mem_w_data", mem_w_data, 32'hDEADBEEF);
        chk("wr_mem_addr", mem_addr, 32'h100);
        chk("wr_dmem_ready", 32'(dmem_ready), 32'h1);
        tick();
        idle();
        tick();

        // Error and ready together: error wins.
        drv(1'b0, 32'h0, 1'b1, 32'h104, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drv(1'b0, 32'h0, 1'b1, 32'h104, 4'h0, 32'h0, 1'b1, 1'b1, 32'h55);
        #2;
        chk("err_dmem_error", 32'(dmem_error), 32'h1);
        chk("err_dmem_ready", 32'(dmem_ready), 32'h0);
        chk("err_dmem_data", dmem_in_data, 32'h0);
        tick();
        idle();
        #2;
        chk("err_mem_en", 32'(mem_en), 32'h0);
        chk("err_grant", 32'(grant), 32'h0);
        tick();

        // Silent memory: timeout after TIMEOUT cycles, then a stray ready.
        drv(1'b1, 32'h80, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            #2;
            chk("to_early_error", 32'(imem_error), 32'h0);
            tick();
        end
        #2;
        chk("to_error", 32'(imem_error), 32'h1);
        chk("to_mem_en_c5", 32'(mem_en), 32'h1);
        tick();
        idle();
        #2;
        chk("to_mem_en_c6", 32'(mem_en), 32'h0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h77);
        #2;
        chk("stray_ready", 32'(imem_ready), 32'h0);
        chk("stray_data", imem_in_data, 32'h0);
        tick();
        idle();
        tick();

        // Reset while a data access is waiting.
        drv(1'b0, 32'h0, 1'b1, 32'h400, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        drv(1'b0, 32'h0, 1'b1, 32'h400, 4'h0, 32'h0, 1'b1, 1'b0, 32'h99);
        #2;
        chk("rstmid_ready", 32'(dmem_ready), 32'h0);
        chk("rstmid_error", 32'(dmem_error), 32'h0);
        tick();
        rst = 1'b0;
        drv(1'b1, 32'h10, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("rstmid_mem_en", 32'(mem_en), 32'h0);
        chk("rstmid_grant", 32'(grant), 32'h0);
        tick();
        #2;
        chk("rstmid_tie_grant", 32'(grant), 32'h2);
        tick();
        drv(1'b0, 32'h10, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0, 32'h5);
        tick();
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
